// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared definitions for the multiply/divide unit.
//   - mdu_op_e      : MDU_op encodings, kept alongside the ALU op encodings
//   - *_CYCLES_DEF  : default busy latencies for mult/multu and div/divu
//   - CNT_W         : width of the latency down-counter
//   - is_long_op    : true for the ops that run through the BUSY state
package mdu_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W           = 8;

  function automatic logic is_long_op(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational arithmetic core of the MDU.
//   op          in   4   MDU operation select
//   src_a       in  32   rs operand (multiplicand / dividend)
//   src_b       in  32   rt operand (multiplier / divisor)
//   result      out 64   {hi, lo}: product, or {remainder, quotient}
//   div_by_zero out  1   div/divu with src_b == 0; result is meaningless
module mdu_arith
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               b_zero;
  logic               s_ovf;
  logic        [31:0] div_b_s;
  logic        [31:0] div_b_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;

  assign a_sx   = $signed({{32{src_a[31]}}, src_a});
  assign b_sx   = $signed({{32{src_b[31]}}, src_b});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  assign b_zero = (src_b == 32'd0);
  // INT_MIN / -1 overflows; dividing by 1 instead yields the wanted
  // quotient 0x80000000 with remainder 0 and avoids the divider corner.
  assign s_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

  assign div_b_s = (b_zero || s_ovf) ? 32'd1 : src_b;
  assign div_b_u = b_zero ? 32'd1 : src_b;

  // SV signed divide truncates toward zero and the remainder takes the
  // dividend's sign, which is exactly the MIPS div semantics.
  assign quo_s = $signed(src_a) / $signed(div_b_s);
  assign rem_s = $signed(src_a) % $signed(div_b_s);
  assign quo_u = src_a / div_b_u;
  assign rem_u = src_a % div_b_u;

  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MDU_MULT:  result = prod_s;
      MDU_MULTU: result = prod_u;
      MDU_DIV: begin
        div_by_zero = b_zero;
        result      = {rem_s, quo_s};
      end
      MDU_DIVU: begin
        div_by_zero = b_zero;
        result      = {rem_u, quo_u};
      end
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the E stage; owns HI/LO.
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous active-low reset
//   MDU_op   in   4   operation select (mdu_op_e)
//   start    in   1   E-stage instruction is an MDU op this cycle
//   cancel   in   1   exception/interrupt taken; suppresses start
//   srcA     in  32   rs operand
//   srcB     in  32   rt operand
//   busy     out  1   multi-cycle operation in progress (registered)
//   HI       out 32   HI register
//   LO       out 32   LO register
//   MDU_out  out 32   mfhi -> HI, mflo -> LO, else 0
//
// state | meaning
// IDLE  | accepts starts; mthi/mtlo write directly
// BUSY  | counting down a mult/div latency; result commits when cnt == 1
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      temp_hi;
  logic [31:0]      temp_lo;
  logic             temp_dz;

  logic [63:0]      arith_res;
  logic             arith_dz;
  logic             eff_start;
  logic             is_mul;

  mdu_arith u_arith (
    .op          (MDU_op),
    .src_a       (srcA),
    .src_b       (srcB),
    .result      (arith_res),
    .div_by_zero (arith_dz)
  );

  // Starts arriving while BUSY are a hazard-unit bug and are dropped here.
  assign eff_start = start && !cancel && (state == ST_IDLE);
  assign is_mul    = (MDU_op == MDU_MULT) || (MDU_op == MDU_MULTU);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      temp_hi <= 32'd0;
      temp_lo <= 32'd0;
      temp_dz <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eff_start) begin
            if (is_long_op(MDU_op)) begin
              temp_hi <= arith_res[63:32];
              temp_lo <= arith_res[31:0];
              temp_dz <= arith_dz;
              cnt     <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
              state   <= ST_BUSY;
            end else if (MDU_op == MDU_MTHI) begin
              HI <= srcA;
            end else if (MDU_op == MDU_MTLO) begin
              LO <= srcA;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            // Divide by zero still burns the full latency but leaves HI/LO.
            if (!temp_dz) begin
              HI <= temp_hi;
              LO <= temp_lo;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_BUSY);

  always_comb begin
    MDU_out = 32'd0;
    if (MDU_op == MDU_MFHI)      MDU_out = HI;
    else if (MDU_op == MDU_MFLO) MDU_out = LO;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl. Multi-cycle results are queued
// at issue and checked (HI, LO, busy length) when busy falls.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  MDU_op;
  logic        start;
  logic        cancel;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          run_len = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .MDU_op  (MDU_op),
    .start   (start),
    .cancel  (cancel),
    .srcA    (srcA),
    .srcB    (srcB),
    .busy    (busy),
    .HI      (HI),
    .LO      (LO),
    .MDU_out (MDU_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: busy falling edge means a multi-cycle op finished.
  always @(negedge clk) begin
    if (!reset) begin
      run_len   = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        run_len++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          check_val("unexpected_done", 64'(sb.size()), 64'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("hi", HI, e.hi);
          check_val("lo", LO, e.lo);
          check_val("busy_len", 64'(run_len), 64'(e.cycles));
        end
        run_len = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic canc);
    @(posedge clk);
    #1;
    check_val("start_while_busy", 64'(busy), 64'd0);
    MDU_op = op;
    srcA   = a;
    srcB   = b;
    start  = 1'b1;
    cancel = canc;
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    MDU_op = MDU_NONE;
  endtask

  task automatic issue_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
    exp_t e;
    e.hi = ehi;
    e.lo = elo;
    e.cycles = cyc;
    sb.push_back(e);
    m_hi = ehi;
    m_lo = elo;
    issue(op, a, b, 1'b0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge clk);
    end
    check_val("done_timeout", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    reset  = 1'b0;
    MDU_op = MDU_NONE;
    start  = 1'b0;
    cancel = 1'b0;
    srcA   = 32'd0;
    srcB   = 32'd0;
    #7;
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_hi", HI, 64'd0);
    check_val("rst_lo", LO, 64'd0);
    check_val("rst_out", MDU_out, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // mthi then mflo / mfhi
    issue(MDU_MTHI, 32'h1234_5678, 32'd0, 1'b0);
    m_hi = 32'h1234_5678;
    MDU_op = MDU_MFLO;
    @(negedge clk);
    check_val("mflo", MDU_out, 64'd0);
    check_val("mthi_busy", 64'(busy), 64'd0);
    MDU_op = MDU_MFHI;
    #1;
    check_val("mfhi", MDU_out, 64'h1234_5678);
    MDU_op = MDU_NONE;
    #1;
    check_val("out_none", MDU_out, 64'd0);

    issue_exp(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_done();
    issue_exp(MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 10);
    wait_done();
    issue_exp(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    wait_done();

    // cancelled start must not do anything
    issue(MDU_MULT, 32'd5, 32'd5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_val("cancel_busy", 64'(busy), 64'd0);
    end
    check_val("cancel_hi", HI, m_hi);
    check_val("cancel_lo", LO, m_lo);

    issue_exp(MDU_MULT, 32'd5, 32'd5, 32'd0, 32'd25, 5);
    wait_done();
    issue_exp(MDU_DIV, 32'd9, 32'd0, m_hi, m_lo, 10);
    wait_done();
    issue_exp(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);
    wait_done();

    // mtlo, then cancel during BUSY is ignored
    issue(MDU_MTLO, 32'hCAFE_F00D, 32'd0, 1'b0);
    m_lo = 32'hCAFE_F00D;
    @(negedge clk);
    check_val("mtlo", LO, 64'hCAFE_F00D);
    issue_exp(MDU_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 5);
    cancel = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    cancel = 1'b0;
    wait_done();

    // random unsigned ops against a 64-bit reference
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a, b;
      logic [63:0] p;
      a = $urandom();
      b = $urandom();
      p = {32'd0, a} * {32'd0, b};
      issue_exp(MDU_MULTU, a, b, p[63:32], p[31:0], 5);
      wait_done();
      b = $urandom_range(1, 65535);
      issue_exp(MDU_DIVU, a, b, a % b, a / b, 10);
      wait_done();
    end

    // asynchronous reset during busy cycle 3 of a divu
    issue(MDU_DIVU, 32'd100, 32'd7, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    check_val("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_hi", HI, 64'd0);
    check_val("arst_lo", LO, 64'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) @(negedge clk);
    check_val("discard_busy", 64'(busy), 64'd0);
    check_val("discard_lo", LO, 64'd0);
    issue_exp(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
